// File: rtl/wave_ctl.sv
// Game-flow controller: counts enemy kills, detects wave clearance, paces the
// inter-wave pause on frame ticks, advances the level and owns game-over/win.
module wave_ctl #(
    parameter int unsigned N            = 8,
    parameter int unsigned MAX_LEVEL    = 9,
    parameter int unsigned PAUSE_FRAMES = 120
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         vsync_in,
    input  logic         start,
    input  logic         player_dead,
    input  logic [N-1:0] lives,
    output logic [3:0]   level,
    output logic         respawn,
    output logic [9:0]   kills,
    output logic [2:0]   state_out,
    output logic         game_over,
    output logic         win
);

    localparam int unsigned LVL_W  = 4;
    localparam int unsigned KILL_W = 10;
    localparam int unsigned FRM_W  = 8;
    localparam int unsigned POP_W  = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPAWN = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;
    localparam logic [2:0] ST_WIN   = 3'd5;

    localparam logic [KILL_W-1:0] KILLS_MAX = '1;

    logic [N-1:0]       lives_q, lives_qq;
    logic               vsync_q, vsync_qq;
    logic               start_q, dead_q;
    logic [2:0]         state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [KILL_W-1:0]  kills_q, kills_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic               armed_q, armed_d;
    logic               respawn_q, respawn_d;
    logic               game_over_q, game_over_d;
    logic               win_q, win_d;

    logic [N-1:0]       kill_vec;
    logic [POP_W-1:0]   kill_pop;
    logic [KILL_W:0]    kill_sum;
    logic               frame_tick;
    logic               wave_clr;

    // State and datapath registers
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            lives_q     <= '0;
            lives_qq    <= '0;
            vsync_q     <= 1'b0;
            vsync_qq    <= 1'b0;
            start_q     <= 1'b0;
            dead_q      <= 1'b0;
            state_q     <= ST_IDLE;
            level_q     <= LVL_W'(1);
            kills_q     <= '0;
            frame_q     <= '0;
            armed_q     <= 1'b0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            lives_q     <= lives;
            lives_qq    <= lives_q;
            vsync_q     <= vsync_in;
            vsync_qq    <= vsync_q;
            start_q     <= start;
            dead_q      <= player_dead;
            state_q     <= state_d;
            level_q     <= level_d;
            kills_q     <= kills_d;
            frame_q     <= frame_d;
            armed_q     <= armed_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
        end
    end

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        kills_d  = kills_q;
        frame_d  = frame_q;
        armed_d  = armed_q;

        kill_vec = lives_qq & ~lives_q;
        kill_pop = '0;
        for (int i = 0; i < int'(N); i++) begin
            kill_pop = kill_pop + POP_W'(kill_vec[i]);
        end
        kill_sum   = (KILL_W+1)'(kills_q) + (KILL_W+1)'(kill_pop);
        frame_tick = vsync_q & ~vsync_qq;
        // armed blocks a clear until the new wave has actually shown up
        wave_clr   = (state_q == ST_PLAY) && armed_q && (lives_q == '0);

        if (state_q == ST_PLAY) begin
            if (lives_q != '0) armed_d = 1'b1;
            kills_d = (kill_sum > (KILL_W+1)'(KILLS_MAX)) ? KILLS_MAX
                                                          : kill_sum[KILL_W-1:0];
        end

        case (state_q)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start_q) begin
                    state_d = ST_SPAWN;
                    level_d = LVL_W'(1);
                    kills_d = '0;
                end
            end
            ST_SPAWN: state_d = ST_PLAY;
            ST_PLAY: begin
                if (dead_q) begin
                    state_d = ST_OVER;
                end else if (wave_clr) begin
                    state_d = ST_PAUSE;
                    frame_d = '0;
                end
            end
            ST_PAUSE: begin
                if (dead_q) begin
                    state_d = ST_OVER;
                end else if (frame_tick) begin
                    if (frame_q == FRM_W'(PAUSE_FRAMES - 1)) begin
                        if (level_q < LVL_W'(MAX_LEVEL)) begin
                            level_d = level_q + LVL_W'(1);
                            state_d = ST_SPAWN;
                        end else begin
                            state_d = ST_WIN;
                        end
                    end else begin
                        frame_d = frame_q + FRM_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_SPAWN) armed_d = 1'b0;

        respawn_d   = (state_d == ST_SPAWN);
        game_over_d = (state_d == ST_OVER);
        win_d       = (state_d == ST_WIN);
    end

    assign level     = level_q;
    assign respawn   = respawn_q;
    assign kills     = kills_q;
    assign state_out = state_q;
    assign game_over = game_over_q;
    assign win       = win_q;

endmodule

// File: tb/tb_wave_ctl.sv
// Scenario bench for wave_ctl: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_wave_ctl;

    localparam int unsigned N = 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_SPAWN = 3'd1, S_PLAY = 3'd2,
                           S_PAUSE = 3'd3, S_OVER = 3'd4, S_WIN = 3'd5;

    logic         pclk = 1'b0;
    logic         rst = 1'b0;
    logic         vsync_in = 1'b0;
    logic         start = 1'b0;
    logic         player_dead = 1'b0;
    logic [N-1:0] lives = '0;
    logic [3:0]   level;
    logic         respawn;
    logic [9:0]   kills;
    logic [2:0]   state_out;
    logic         game_over;
    logic         win;

    int n_pass = 0;
    int n_total = 0;
    int resp_cnt = 0;
    int exp_q[$];
    int e;
    int r0;

    wave_ctl #(.N(N), .MAX_LEVEL(2), .PAUSE_FRAMES(3)) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start),
        .player_dead(player_dead), .lives(lives), .level(level),
        .respawn(respawn), .kills(kills), .state_out(state_out),
        .game_over(game_over), .win(win)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (respawn === 1'b1) resp_cnt++;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1; step(2);
        vsync_in = 1'b0; step(2);
    endtask

    task automatic wave_to_pause();
        lives = 8'hFF; step(3);
        lives = 8'h00; step(2);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        exp_q.push_back(1); exp_q.push_back(S_IDLE); exp_q.push_back(0); exp_q.push_back(0);
        step(2);
        e = exp_q.pop_front(); n_total++;
        if (level !== 4'(e)) $display("FAIL reset_level got %0d want %0d", level, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL reset_state got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL reset_kills got %0d want %0d", kills, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if ({respawn, game_over, win} !== 3'(e)) $display("FAIL reset_flags got %b want %0d", {respawn, game_over, win}, e); else n_pass++;
        rst = 1'b1;
        exp_q.push_back(S_IDLE);
        step(4);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL idle_hold got %0d want %0d", state_out, e); else n_pass++;
    endtask

    task automatic test_start();
        r0 = resp_cnt;
        start = 1'b1;
        exp_q.push_back(S_IDLE); exp_q.push_back(S_SPAWN); exp_q.push_back(1);
        exp_q.push_back(S_PLAY); exp_q.push_back(0);
        step(1);
        start = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL start_k1_state got %0d want %0d", state_out, e); else n_pass++;
        step(1);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL start_spawn got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (respawn !== 1'(e)) $display("FAIL start_respawn got %b want %0d", respawn, e); else n_pass++;
        step(1);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL start_play got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (respawn !== 1'(e)) $display("FAIL start_respawn_end got %b want %0d", respawn, e); else n_pass++;
        step(2);
        exp_q.push_back(r0 + 1);
        e = exp_q.pop_front(); n_total++;
        if (resp_cnt !== e) $display("FAIL start_pulse_count got %0d want %0d", resp_cnt, e); else n_pass++;
    endtask

    task automatic test_simul_kills();
        lives = 8'hFF;
        exp_q.push_back(0);
        step(3);
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL kills_before got %0d want %0d", kills, e); else n_pass++;
        lives = 8'hF0;
        exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(S_PLAY);
        step(3);
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL kills_simul got %0d want %0d", kills, e); else n_pass++;
        step(2);
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL kills_stable got %0d want %0d", kills, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL kills_state got %0d want %0d", state_out, e); else n_pass++;
    endtask

    task automatic test_wave_clear();
        start = 1'b1;
        exp_q.push_back(S_PLAY);
        step(4);
        start = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL start_ignored_play got %0d want %0d", state_out, e); else n_pass++;
        r0 = resp_cnt;
        lives = 8'h00;
        exp_q.push_back(S_PLAY); exp_q.push_back(S_PAUSE); exp_q.push_back(8);
        step(1);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL clear_k1 got %0d want %0d", state_out, e); else n_pass++;
        step(1);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL clear_pause got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL clear_kills got %0d want %0d", kills, e); else n_pass++;
        exp_q.push_back(S_PAUSE); exp_q.push_back(1);
        vsync_pulse();
        vsync_pulse();
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL pause_two_frames got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (level !== 4'(e)) $display("FAIL pause_level_hold got %0d want %0d", level, e); else n_pass++;
        vsync_in = 1'b1;
        exp_q.push_back(S_SPAWN); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(S_PLAY);
        step(2);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL advance_spawn got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (level !== 4'(e)) $display("FAIL advance_level got %0d want %0d", level, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (respawn !== 1'(e)) $display("FAIL advance_respawn got %b want %0d", respawn, e); else n_pass++;
        vsync_in = 1'b0;
        step(3);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL advance_play got %0d want %0d", state_out, e); else n_pass++;
        exp_q.push_back(r0 + 1);
        e = exp_q.pop_front(); n_total++;
        if (resp_cnt !== e) $display("FAIL advance_pulse_count got %0d want %0d", resp_cnt, e); else n_pass++;
    endtask

    task automatic test_win_restart();
        r0 = resp_cnt;
        wave_to_pause();
        vsync_pulse();
        vsync_pulse();
        vsync_pulse();
        exp_q.push_back(S_WIN); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(16);
        exp_q.push_back(r0);
        step(3);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL win_state got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (win !== 1'(e)) $display("FAIL win_flag got %b want %0d", win, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (level !== 4'(e)) $display("FAIL win_level got %0d want %0d", level, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL win_kills got %0d want %0d", kills, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (resp_cnt !== e) $display("FAIL win_no_respawn got %0d want %0d", resp_cnt, e); else n_pass++;
        start = 1'b1;
        exp_q.push_back(S_SPAWN); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        step(2);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL restart_spawn got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (level !== 4'(e)) $display("FAIL restart_level got %0d want %0d", level, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL restart_kills got %0d want %0d", kills, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (respawn !== 1'(e)) $display("FAIL restart_respawn got %b want %0d", respawn, e); else n_pass++;
        exp_q.push_back(S_PLAY); exp_q.push_back(r0 + 1);
        step(6);
        start = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL start_held_state got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (resp_cnt !== e) $display("FAIL start_held_pulses got %0d want %0d", resp_cnt, e); else n_pass++;
    endtask

    task automatic test_spurious_clear();
        exp_q.push_back(S_PLAY); exp_q.push_back(0);
        step(10);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL spurious_state got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL spurious_kills got %0d want %0d", kills, e); else n_pass++;
    endtask

    task automatic test_death_priority();
        wave_to_pause();
        vsync_pulse();
        vsync_pulse();
        vsync_pulse();
        lives = 8'hFF;
        step(3);
        player_dead = 1'b1;
        lives = 8'h00;
        exp_q.push_back(S_OVER); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(S_OVER);
        step(2);
        player_dead = 1'b0;
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL death_state got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (game_over !== 1'(e)) $display("FAIL death_flag got %b want %0d", game_over, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (level !== 4'(e)) $display("FAIL death_level got %0d want %0d", level, e); else n_pass++;
        step(4);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL over_hold got %0d want %0d", state_out, e); else n_pass++;
    endtask

    task automatic test_mid_reset();
        start = 1'b1; step(3); start = 1'b0;
        wave_to_pause();
        vsync_pulse();
        exp_q.push_back(S_PAUSE);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL pre_reset_pause got %0d want %0d", state_out, e); else n_pass++;
        r0 = resp_cnt;
        rst = 1'b0;
        exp_q.push_back(S_IDLE); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL midrst_state got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (level !== 4'(e)) $display("FAIL midrst_level got %0d want %0d", level, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (kills !== 10'(e)) $display("FAIL midrst_kills got %0d want %0d", kills, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if ({respawn, game_over, win} !== 3'(e)) $display("FAIL midrst_flags got %b want %0d", {respawn, game_over, win}, e); else n_pass++;
        step(3);
        rst = 1'b1;
        exp_q.push_back(S_IDLE); exp_q.push_back(r0);
        step(3);
        e = exp_q.pop_front(); n_total++;
        if (state_out !== 3'(e)) $display("FAIL postrst_idle got %0d want %0d", state_out, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (resp_cnt !== e) $display("FAIL postrst_no_respawn got %0d want %0d", resp_cnt, e); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_simul_kills();
        test_wave_clear();
        test_win_restart();
        test_spurious_clear();
        test_death_priority();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
